can_tx_frame_serializer: RTL and testbench

//  Transmit-side frame engine: turns a queued CAN frame (ID, IDE, RTR, DLC, payload)

---
 rtl/can_tx_frame_serializer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_can_tx_frame_serializer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_frame_serializer.sv
// can_tx_frame_serializer
//   Transmit-side CAN frame engine. Latches a frame on start and serializes it
//   as SOF, arbitration, control, data, CRC-15, delimiters and EOF. It inserts
//   stuff bits, watches for lost arbitration and samples the ACK slot. One bit,
//   stuff bits included, is driven on the cycle after each tx_point strobe.
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   tx_point          strobe: drive the next bit on tx
//   sample_point      strobe: rx holds the bus level of the current bit
//   rx                sampled bus level (0 = dominant)
//   start             frame request, accepted only while idle
//   ide, rtr, id,
//   dlc, data         frame contents, latched on acceptance
//   tx                bus drive (1 = recessive)
//   busy              frame in progress
//   done              1-cycle pulse once the last EOF bit has been ended
//   ack_ok            ACK slot was sampled dominant (meaningful with done)
//   arb_lost          1-cycle pulse when arbitration is lost
module can_tx_frame_serializer #(
    parameter int EOF_BITS    = 7,
    parameter int STUFF_LIMIT = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_point,
    input  logic        sample_point,
    input  logic        rx,
    input  logic        start,
    input  logic        ide,
    input  logic        rtr,
    input  logic [28:0] id,
    input  logic [3:0]  dlc,
    input  logic [63:0] data,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic        ack_ok,
    output logic        arb_lost
);
    localparam int            RW      = $clog2(STUFF_LIMIT + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(STUFF_LIMIT);
    localparam logic [RW-1:0] RUN_ONE = RW'(1);
    localparam logic [6:0]    EOF_N   = 7'(EOF_BITS);

    typedef enum logic [3:0] {
        S_IDLE, S_SOF, S_ARB, S_CTRL, S_DATA, S_CRC,
        S_CRC_DEL, S_ACK_SLOT, S_ACK_DEL, S_EOF
    } state_t;

    // state_q names the field of the NEXT bit to drive; cur_*_q describe the
    // bit currently on tx, which is what sample_point refers to.
    state_t        state_q, state_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic          ack_q, ack_d;
    logic          arbl_q, arbl_d;
    logic          ide_q, ide_d;
    logic [31:0]   arb_q, arb_d;      // arbitration bits, MSB first
    logic [5:0]    ctrl_q, ctrl_d;    // control bits, MSB first
    logic [63:0]   data_q, data_d;
    logic [6:0]    dbits_q, dbits_d;  // number of data bits to send
    logic [14:0]   crc_q, crc_d;
    logic [6:0]    cnt_q, cnt_d;      // bit index inside the current field
    logic [RW-1:0] run_q, run_d;      // length of current equal-bit run
    logic          last_q, last_d;
    logic          cur_arb_q, cur_arb_d;
    logic          cur_ack_q, cur_ack_d;

    logic       fbit, do_crc, do_run;
    logic [6:0] arb_last, ctrl_last;

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        logic fb;
        fb = b ^ c[14];
        crc_step = {c[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
    endfunction

    assign arb_last  = ide_q ? 7'd31 : 7'd12;
    assign ctrl_last = ide_q ? 7'd5  : 7'd4;

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        ack_d     = ack_q;
        arbl_d    = 1'b0;
        ide_d     = ide_q;
        arb_d     = arb_q;
        ctrl_d    = ctrl_q;
        data_d    = data_q;
        dbits_d   = dbits_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        run_d     = run_q;
        last_d    = last_q;
        cur_arb_d = cur_arb_q;
        cur_ack_d = cur_ack_q;
        fbit      = 1'b1;
        do_crc    = 1'b0;
        do_run    = 1'b0;

        if (state_q == S_IDLE) begin
            // A start coinciding with the done pulse is dropped.
            if (start && !done_q) begin
                state_d   = S_SOF;
                ide_d     = ide;
                arb_d     = ide ? {id[28:18], 1'b1, 1'b1, id[17:0], rtr}
                                : {id[10:0], rtr, 1'b0, 19'd0};
                ctrl_d    = ide ? {2'b00, dlc} : {1'b0, dlc, 1'b0};
                data_d    = data;
                dbits_d   = rtr ? 7'd0 : ((dlc > 4'd8) ? 7'd64 : {dlc, 3'b000});
                crc_d     = '0;
                cnt_d     = '0;
                run_d     = '0;
                last_d    = 1'b0;
                ack_d     = 1'b0;
                cur_arb_d = 1'b0;
                cur_ack_d = 1'b0;
            end
        end else if (sample_point && cur_arb_q && tx_q && !rx) begin
            // Lost arbitration beats a tx_point in the same cycle.
            arbl_d    = 1'b1;
            tx_d      = 1'b1;
            state_d   = S_IDLE;
            cur_arb_d = 1'b0;
            cur_ack_d = 1'b0;
        end else begin
            if (sample_point && cur_ack_q)
                ack_d = ~rx;
            if (tx_point) begin
                cur_arb_d = 1'b0;
                cur_ack_d = 1'b0;
                if (run_q == RUN_MAX && state_q inside {S_ARB, S_CTRL, S_DATA, S_CRC, S_CRC_DEL}) begin
                    // Stuff bit; it belongs to the field whose bit comes next.
                    tx_d      = ~last_q;
                    last_d    = ~last_q;
                    run_d     = (state_q == S_CRC_DEL) ? '0 : RUN_ONE;
                    cur_arb_d = (state_q == S_ARB);
                end else begin
                    case (state_q)
                        S_SOF: begin
                            fbit    = 1'b0;
                            do_crc  = 1'b1;
                            do_run  = 1'b1;
                            state_d = S_ARB;
                            cnt_d   = '0;
                        end
                        S_ARB: begin
                            fbit      = arb_q[31];
                            arb_d     = {arb_q[30:0], 1'b0};
                            do_crc    = 1'b1;
                            do_run    = 1'b1;
                            cur_arb_d = 1'b1;
                            if (cnt_q == arb_last) begin
                                state_d = S_CTRL;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + 7'd1;
                            end
                        end
                        S_CTRL: begin
                            fbit   = ctrl_q[5];
                            ctrl_d = {ctrl_q[4:0], 1'b0};
                            do_crc = 1'b1;
                            do_run = 1'b1;
                            if (cnt_q == ctrl_last) begin
                                state_d = (dbits_q == 7'd0) ? S_CRC : S_DATA;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + 7'd1;
                            end
                        end
                        S_DATA: begin
                            fbit   = data_q[63];
                            data_d = {data_q[62:0], 1'b0};
                            do_crc = 1'b1;
                            do_run = 1'b1;
                            if (cnt_q == dbits_q - 7'd1) begin
                                state_d = S_CRC;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + 7'd1;
                            end
                        end
                        S_CRC: begin
                            // The CRC register doubles as the output shifter.
                            fbit   = crc_q[14];
                            crc_d  = {crc_q[13:0], 1'b0};
                            do_run = 1'b1;
                            if (cnt_q == 7'd14) begin
                                state_d = S_CRC_DEL;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + 7'd1;
                            end
                        end
                        S_CRC_DEL:  state_d = S_ACK_SLOT;
                        S_ACK_SLOT: begin
                            state_d   = S_ACK_DEL;
                            cur_ack_d = 1'b1;
                        end
                        S_ACK_DEL: begin
                            state_d = S_EOF;
                            cnt_d   = '0;
                        end
                        S_EOF: begin
                            // This tx_point ends the last EOF bit.
                            if (cnt_q == EOF_N) begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                cnt_d = cnt_q + 7'd1;
                            end
                        end
                        default: ;
                    endcase
                    tx_d = fbit;
                    if (do_crc)
                        crc_d = crc_step(crc_q, fbit);
                    if (do_run) begin
                        run_d  = (run_q != '0 && fbit == last_q) ? run_q + RUN_ONE : RUN_ONE;
                        last_d = fbit;
                    end else begin
                        run_d = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
            arbl_q    <= 1'b0;
            ide_q     <= 1'b0;
            arb_q     <= '0;
            ctrl_q    <= '0;
            data_q    <= '0;
            dbits_q   <= '0;
            crc_q     <= '0;
            cnt_q     <= '0;
            run_q     <= '0;
            last_q    <= 1'b0;
            cur_arb_q <= 1'b0;
            cur_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            ack_q     <= ack_d;
            arbl_q    <= arbl_d;
            ide_q     <= ide_d;
            arb_q     <= arb_d;
            ctrl_q    <= ctrl_d;
            data_q    <= data_d;
            dbits_q   <= dbits_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            last_q    <= last_d;
            cur_arb_q <= cur_arb_d;
            cur_ack_q <= cur_ack_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign ack_ok   = ack_q;
    assign arb_lost = arbl_q;

endmodule

// File: tb/tb_can_tx_frame_serializer.sv
// tb_can_tx_frame_serializer
//   Builds each frame's expected bus stream from the frame rules (field list,
//   CRC-15 over the unstuffed bits, then stuffing), drives tx_point/sample_point
//   with randomized in-bit sample positions and loops tx back to rx, forcing
//   dominant levels for ACK and arbitration cases.
module tb_can_tx_frame_serializer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_point = 1'b0;
    logic        sample_point = 1'b0;
    logic        start = 1'b0;
    logic        ide = 1'b0;
    logic        rtr = 1'b0;
    logic [28:0] id = '0;
    logic [3:0]  dlc = '0;
    logic [63:0] data = '0;
    logic        rx_force = 1'b0;
    logic        rx_w;
    logic        tx_w, busy_w, done_w, ack_w, arbl_w;

    assign rx_w = rx_force ? 1'b0 : tx_w;

    always #5 clk = ~clk;

    can_tx_frame_serializer dut (
        .clk(clk), .rst_n(rst_n), .tx_point(tx_point), .sample_point(sample_point),
        .rx(rx_w), .start(start), .ide(ide), .rtr(rtr), .id(id), .dlc(dlc), .data(data),
        .tx(tx_w), .busy(busy_w), .done(done_w), .ack_ok(ack_w), .arb_lost(arbl_w)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected outputs, compared every cycle at the falling edge.
    logic chk_en = 1'b0;
    logic exp_tx = 1'b1, exp_busy = 1'b0, exp_done = 1'b0, exp_arb = 1'b0, exp_ack = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx", {31'd0, tx_w}, {31'd0, exp_tx});
            chk("busy", {31'd0, busy_w}, {31'd0, exp_busy});
            chk("done", {31'd0, done_w}, {31'd0, exp_done});
            chk("arb_lost", {31'd0, arbl_w}, {31'd0, exp_arb});
            if (exp_done)
                chk("ack_ok", {31'd0, ack_w}, {31'd0, exp_ack});
        end
    end

    // Model: emitted bits with tags 0 other, 1 arbitration field, 2 data, 3 stuff.
    int          m_bits[$];
    int          m_tag[$];
    int          m_ack_idx;
    int          m_stuffs;
    logic [14:0] m_crc;

    function automatic logic [14:0] crc15(input int q[$]);
        logic [14:0] c;
        logic fb;
        c = '0;
        foreach (q[i]) begin
            fb = (q[i] != 0) ^ c[14];
            c = {c[13:0], 1'b0};
            if (fb) c = c ^ 15'h4599;
        end
        return c;
    endfunction

    task automatic build(input logic fide, input logic frtr, input logic [28:0] fid,
                         input logic [3:0] fdlc, input logic [63:0] fdata);
        int u[$];   // unstuffed entries: bit | tag<<1
        int ub[$];
        int nbytes, run, lastb, b;
        u.push_back(0);
        if (fide) begin
            for (int i = 28; i >= 18; i--) u.push_back(int'(fid[i]) | 2);
            u.push_back(3); u.push_back(3);
            for (int i = 17; i >= 0; i--) u.push_back(int'(fid[i]) | 2);
            u.push_back(int'(frtr) | 2);
            u.push_back(0); u.push_back(0);
        end else begin
            for (int i = 10; i >= 0; i--) u.push_back(int'(fid[i]) | 2);
            u.push_back(int'(frtr) | 2);
            u.push_back(2);
            u.push_back(0);
        end
        for (int i = 3; i >= 0; i--) u.push_back(int'(fdlc[i]));
        nbytes = frtr ? 0 : ((fdlc > 8) ? 8 : int'(fdlc));
        for (int i = 0; i < nbytes * 8; i++) u.push_back(int'(fdata[63 - i]) | 4);
        foreach (u[i]) ub.push_back(u[i] & 1);
        m_crc = crc15(ub);
        for (int i = 14; i >= 0; i--) u.push_back(int'(m_crc[i]));
        m_bits.delete(); m_tag.delete();
        m_stuffs = 0; run = 0; lastb = 0;
        foreach (u[i]) begin
            b = u[i] & 1;
            m_bits.push_back(b); m_tag.push_back(u[i] >> 1);
            run = (run > 0 && b == lastb) ? run + 1 : 1;
            lastb = b;
            if (run == 5) begin
                m_bits.push_back(1 - b); m_tag.push_back(3);
                m_stuffs++; lastb = 1 - b; run = 1;
            end
        end
        m_bits.push_back(1); m_tag.push_back(0);
        m_ack_idx = m_bits.size();
        m_bits.push_back(1); m_tag.push_back(0);
        m_bits.push_back(1); m_tag.push_back(0);
        for (int i = 0; i < 7; i++) begin m_bits.push_back(1); m_tag.push_back(0); end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic force_at(input int j, input logic ad, input int li);
        return (j == li) || (ad && j == m_ack_idx);
    endfunction

    task automatic lost();
        exp_arb = 1'b1; exp_busy = 1'b0; exp_tx = 1'b1;
        tick();
        exp_arb = 1'b0;
    endtask

    task automatic run_frame(input logic fide, input logic frtr, input logic [28:0] fid,
                             input logic [3:0] fdlc, input logic [63:0] fdata,
                             input logic ack_dom, input int lose_idx, input int rst_idx,
                             input logic start_at_done);
        int n, s;
        logic coin, ended;
        build(fide, frtr, fid, fdlc, fdata);
        n = m_bits.size();
        ide = fide; rtr = frtr; id = fid; dlc = fdlc; data = fdata; start = 1'b1;
        tick();
        start = 1'b0; exp_busy = 1'b1;
        // Scramble the inputs; a latched frame must not follow them.
        ide = 1'($urandom); rtr = 1'($urandom); id = 29'($urandom);
        dlc = 4'($urandom); data = {$urandom, $urandom};
        coin = 1'b0; ended = 1'b0;
        for (int k = 0; k <= n && !ended; k++) begin
            s = $urandom_range(1, 4);
            tx_point = 1'b1;
            sample_point = coin;
            rx_force = coin && force_at(k - 1, ack_dom, lose_idx);
            if (k == n / 2) start = 1'b1;
            tick();
            tx_point = 1'b0; sample_point = 1'b0; rx_force = 1'b0; start = 1'b0;
            if (coin && (k - 1) == lose_idx) begin
                lost(); ended = 1'b1;
            end else if (k == n) begin
                exp_done = 1'b1; exp_busy = 1'b0; exp_tx = 1'b1; exp_ack = ack_dom;
                if (start_at_done) start = 1'b1;
                tick();
                start = 1'b0; exp_done = 1'b0;
                tick();
                ended = 1'b1;
            end else begin
                exp_tx = (m_bits[k] != 0);
                coin = 1'b0;
                for (int c = 1; c <= 3 && !ended; c++) begin
                    if (c == s) begin
                        sample_point = 1'b1;
                        rx_force = force_at(k, ack_dom, lose_idx);
                    end
                    if (k == rst_idx && c == 1) rst_n = 1'b0;
                    tick();
                    sample_point = 1'b0; rx_force = 1'b0;
                    if (!rst_n) begin
                        rst_n = 1'b1; exp_tx = 1'b1; exp_busy = 1'b0; ended = 1'b1;
                    end else if (c == s && k == lose_idx) begin
                        lost(); ended = 1'b1;
                    end
                end
                if (s == 4) coin = 1'b1;
            end
        end
    endtask

    initial begin
        int tq[$];
        logic [19:0] hv;
        int cnt, d0;
        logic [1:0] srr_ide;

        // Reset state, with start held high while in reset.
        rst_n = 1'b0;
        repeat (2) tick();
        chk_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("reset_ack_ok", {31'd0, ack_w}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Hand-computed anchors for the model.
        tq.push_back(1);
        chk("pin_crc_single_one", {17'd0, crc15(tq)}, 32'h4599);
        build(1'b0, 1'b0, 29'h123, 4'd0, 64'd0);
        for (int i = 0; i < 20; i++) hv[19 - i] = (m_bits[i] != 0);
        chk("pin_hdr_0x123", {12'd0, hv}, 32'h12304);
        build(1'b0, 1'b0, 29'h000, 4'd0, 64'd0);
        chk("pin_zero_stuffs", m_stuffs, 6);
        chk("pin_zero_len", m_bits.size(), 50);
        chk("pin_zero_crc", {17'd0, m_crc}, 32'd0);
        build(1'b1, 1'b0, 29'h1ABCDEF, 4'd8, 64'h0123456789ABCDEF);
        cnt = 0; srr_ide = '0;
        foreach (m_tag[i]) begin
            if (m_tag[i] == 2) cnt++;
            if (m_tag[i] == 1) begin
                if (d0 == 11) srr_ide[1] = (m_bits[i] != 0);
                if (d0 == 12) srr_ide[0] = (m_bits[i] != 0);
                d0++;
            end
            if (i == 0) d0 = 0;
        end
        chk("pin_ext_data_bits", cnt, 64);
        chk("pin_ext_srr_ide", {30'd0, srr_ide}, 32'd3);
        build(1'b0, 1'b0, 29'h55, 4'd12, 64'hFFFF0000AAAA5555);
        cnt = 0; foreach (m_tag[i]) if (m_tag[i] == 2) cnt++;
        chk("pin_dlc12_bits", cnt, 64);
        build(1'b0, 1'b1, 29'h55, 4'd5, 64'hFFFF0000AAAA5555);
        cnt = 0; foreach (m_tag[i]) if (m_tag[i] == 2) cnt++;
        chk("pin_rtr_bits", cnt, 0);

        // Directed frames.
        run_frame(1'b0, 1'b0, 29'h123, 4'd0, 64'd0, 1'b0, -1, -1, 1'b1);
        run_frame(1'b0, 1'b0, 29'h000, 4'd0, 64'd0, 1'b0, -1, -1, 1'b0);
        run_frame(1'b1, 1'b0, 29'h1ABCDEF, 4'd8, 64'h0123456789ABCDEF, 1'b1, -1, -1, 1'b0);
        run_frame(1'b0, 1'b0, 29'h7FF, 4'd0, 64'd0, 1'b0, 1, -1, 1'b0);
        run_frame(1'b0, 1'b0, 29'h55, 4'd12, 64'hFFFF0000AAAA5555, 1'b1, -1, -1, 1'b0);
        run_frame(1'b0, 1'b1, 29'h55, 4'd5, 64'hFFFF0000AAAA5555, 1'b0, -1, -1, 1'b1);
        build(1'b0, 1'b0, 29'h2A5, 4'd8, 64'hDEADBEEFCAFEF00D);
        d0 = 0;
        for (int i = m_tag.size() - 1; i >= 0; i--) if (m_tag[i] == 2) d0 = i;
        run_frame(1'b0, 1'b0, 29'h2A5, 4'd8, 64'hDEADBEEFCAFEF00D, 1'b0, -1, d0 + 10, 1'b0);
        run_frame(1'b0, 1'b0, 29'h123, 4'd3, 64'h1122334455667788, 1'b1, -1, -1, 1'b0);

        // Randomized frames, some with arbitration loss on a recessive ID bit.
        for (int f = 0; f < 24; f++) begin
            logic fi, fr;
            logic [28:0] fid;
            logic [3:0] fd;
            logic [63:0] fdat;
            int li;
            int cand[$];
            fi = 1'($urandom); fr = ($urandom_range(0, 3) == 0);
            fid = 29'($urandom); fd = 4'($urandom); fdat = {$urandom, $urandom};
            li = -1;
            if ($urandom_range(0, 3) == 0) begin
                build(fi, fr, fid, fd, fdat);
                cand.delete();
                foreach (m_bits[i]) if (m_tag[i] == 1 && m_bits[i] == 1) cand.push_back(i);
                if (cand.size() > 0) li = cand[$urandom_range(0, cand.size() - 1)];
            end
            run_frame(fi, fr, fid, fd, fdat, 1'($urandom), li, -1, 1'($urandom));
        end

        tick();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
